rd_code_gen: RTL
================

RD_CODE_GEN -- requirements
Module: rd_code_gen

Interface
REQ-001 The module SHALL expose parameter PIX_W, default 8, meaning the pixel sample width in bits.
REQ-002 The module SHALL expose parameter NUM_P, default 8, meaning the number of sample pairs per code; only 8 is supported.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be the reset; synchronous and active-high.
REQ-005 i_valid  input  1  SHALL flag that an outer/inner sample pair is presented.
REQ-006 i_outer  input  PIX_W  SHALL be the outer-radius sample, unsigned.
REQ-007 i_inner  input  PIX_W  SHALL be the inner-radius sample, unsigned.
REQ-008 o_ready  output  1  SHALL flag that the block accepts a pair this cycle.
REQ-009 o_addr  output  8  SHALL be the radial-difference code, which drives the weight ROM address.
REQ-010 o_valid  output  1  SHALL flag that o_addr holds a complete code.
REQ-011 i_ready  input  1  SHALL flag that the downstream weight stage accepts o_addr.
REQ-012 o_code_cnt  output  16  SHALL count the codes handed off downstream.

Function
REQ-013 The FSM SHALL have two states: COLLECT (o_ready=1, o_valid=0) and OUT (o_ready=0, o_valid=1).
REQ-014 A pair SHALL be accepted only when i_valid && o_ready are both high in the same cycle.
REQ-015 The k-th accepted pair (k=0..7) SHALL set code bit k = 1 iff i_outer >= i_inner; bit 0 is the first pair (LSB-first).
REQ-016 The comparison SHALL use PIX_W+1-bit unsigned arithmetic with no wrap or overflow.
REQ-017 A 3-bit pair counter SHALL increment on each accept, wrap 7->0 on the 8th accept, and the FSM SHALL enter OUT on that same edge.
REQ-018 o_addr SHALL equal the full 8-bit code in the cycle after the 8th accept (latency 1), and SHALL be held stable while in OUT.
REQ-019 In OUT, the handoff SHALL occur when i_ready is high. On that handoff the FSM SHALL return to COLLECT, clear the code register and increment o_code_cnt.
REQ-020 In OUT, i_valid SHALL be ignored, so no pair is accepted; minimum throughput is 9 cycles per code.
REQ-021 If i_ready stays low, o_valid and o_addr SHALL persist indefinitely.
REQ-022 o_code_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-023 In COLLECT, o_addr SHALL show the partial code register; it is meaningless while o_valid=0.

Reset
REQ-024 While i_rst=1 at a clock edge, the block SHALL set: state=COLLECT, counter=0, code=0, o_addr=0, o_valid=0, o_ready=1 (after reset), o_code_cnt=0.
REQ-025 Reset mid-collection or in OUT SHALL discard the partial or pending code without handoff.
REQ-026 Reset SHALL take priority over a simultaneous accept or handoff.

Configuration
REQ-027 Macro RD_THRESH_EN SHALL, when defined, add input port i_thresh (PIX_W bits, unsigned).
REQ-028 With RD_THRESH_EN defined, bit k SHALL be 1 iff i_outer >= i_inner + i_thresh, computed at PIX_W+1 bits. i_thresh SHALL be sampled per accepted pair.
REQ-029 Without RD_THRESH_EN, the port SHALL be absent and the behaviour SHALL equal a threshold of 0 (REQ-015).

Structure
REQ-030 Shared package mrelbp_pkg SHALL hold PIX_W_DEF=8, NUM_P=8, CODE_W=8, CNT_W=16 and the enum rd_state_e {COLLECT, OUT}.
REQ-031 Combinational sub-module rd_sign_cmp (outer, inner, optional thresh -> 1 bit) SHALL implement REQ-015/REQ-028 and be instantiated once.
REQ-032 o_addr SHALL connect directly to the weight ROM address with no extra register.

Verification
REQ-033 The bench SHALL cover: 8 pairs with outer=100, inner alternating 50/150 (first pair inner=50) -> o_addr=8'h55 and o_valid=1 one cycle after the 8th accept; o_code_cnt=1 after handoff.
REQ-034 The bench SHALL cover: equal pairs, 8x outer=inner=7 -> o_addr=8'hFF; extreme pairs 8x outer=0, inner=255 -> 8'h00.
REQ-035 The bench SHALL cover: i_ready held low for 20 cycles while i_valid=1 in OUT -> o_addr stable, o_ready=0, no pair absorbed; i_ready=1 -> COLLECT the next cycle.
REQ-036 The bench SHALL cover: i_rst pulsed after 5 accepts -> next 8 pairs yield a fresh code, with no contribution from the first 5.
REQ-037 The bench SHALL cover, with RD_THRESH_EN: i_thresh=10, outer=60, inner=50 -> bit=1; outer=59, inner=50 -> bit=0; i_thresh=255, inner=255, outer=255 -> bit=0.
REQ-038 The bench SHALL cover: o_code_cnt preset near saturation by forcing 65535 handoffs (or a shortened sim) -> the counter stays at 16'hFFFF.

Source files
------------

// File: rtl/mrelbp_pkg.sv
// mrelbp_pkg
// Definitions shared by the radial-difference code path: default pixel
// width, pairs per code, code width, handoff-counter width and the
// code-generator state encoding.
package mrelbp_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int NUM_P     = 8;
  localparam int CODE_W    = 8;
  localparam int CNT_W     = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } rd_state_e;

endpackage

// File: rtl/rd_sign_cmp.sv
// rd_sign_cmp
// Combinational sign test for one outer/inner sample pair.
// o_bit = 1 when outer >= inner (+ threshold when RD_THRESH_EN is defined).
// The comparison is done one bit wider than the samples so inner + thresh
// can never wrap.
// Ports:
//   i_thresh  threshold added to the inner sample (RD_THRESH_EN only)
//   i_outer   outer-radius sample, unsigned
//   i_inner   inner-radius sample, unsigned
//   o_bit     resulting code bit
// Configuration macro: RD_THRESH_EN
module rd_sign_cmp #(
  parameter int PIX_W = 8
) (
`ifdef RD_THRESH_EN
  input  logic [PIX_W-1:0] i_thresh,
`endif
  input  logic [PIX_W-1:0] i_outer,
  input  logic [PIX_W-1:0] i_inner,
  output logic             o_bit
);

  logic [PIX_W:0] rhs;

`ifdef RD_THRESH_EN
  assign rhs = {1'b0, i_inner} + {1'b0, i_thresh};
`else
  assign rhs = {1'b0, i_inner};
`endif

  assign o_bit = ({1'b0, i_outer} >= rhs);

endmodule

// File: rtl/rd_code_gen.sv
// rd_code_gen
// Collects eight outer/inner sample pairs into an 8-bit radial-difference
// code (first pair in bit 0) and hands the code to the weight stage with a
// valid/ready handshake. o_addr is the code register itself and feeds the
// weight ROM address directly.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   pair handshake (o_ready high only while collecting)
//   i_outer, i_inner    sample pair, unsigned
//   i_thresh            per-pair threshold (RD_THRESH_EN only)
//   o_addr              code / weight ROM address
//   o_valid / i_ready   code handshake toward the weight stage
//   o_code_cnt          saturating count of handed-off codes
// Configuration macro: RD_THRESH_EN
module rd_code_gen #(
  parameter int PIX_W = mrelbp_pkg::PIX_W_DEF,
  parameter int NUM_P = mrelbp_pkg::NUM_P
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [PIX_W-1:0]             i_outer,
  input  logic [PIX_W-1:0]             i_inner,
`ifdef RD_THRESH_EN
  input  logic [PIX_W-1:0]             i_thresh,
`endif
  output logic                         o_ready,
  output logic [mrelbp_pkg::CODE_W-1:0] o_addr,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [mrelbp_pkg::CNT_W-1:0] o_code_cnt
);

  import mrelbp_pkg::*;

  rd_state_e           state_q, state_d;
  logic [2:0]          pair_cnt_q, pair_cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    code_cnt_q, code_cnt_d;
  logic                pair_bit;

  rd_sign_cmp #(
    .PIX_W (PIX_W)
  ) u_sign_cmp (
`ifdef RD_THRESH_EN
    .i_thresh (i_thresh),
`endif
    .i_outer  (i_outer),
    .i_inner  (i_inner),
    .o_bit    (pair_bit)
  );

  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    code_d     = code_q;
    code_cnt_d = code_cnt_q;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state_q)
      COLLECT: begin
        o_ready = 1'b1;
        if (i_valid) begin
          code_d[pair_cnt_q] = pair_bit;
          // 3-bit counter wraps back to 0 on the last pair of a code
          pair_cnt_d = pair_cnt_q + 3'd1;
          if (pair_cnt_q == 3'(NUM_P - 1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        o_valid = 1'b1;
        // Pairs offered while a code is pending are not absorbed.
        if (i_ready) begin
          state_d = COLLECT;
          code_d  = '0;
          if (code_cnt_q != '1) begin
            code_cnt_d = code_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= COLLECT;
      pair_cnt_q <= '0;
      code_q     <= '0;
      code_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      code_q     <= code_d;
      code_cnt_q <= code_cnt_d;
    end
  end

  assign o_addr     = code_q;
  assign o_code_cnt = code_cnt_q;

endmodule
